periph_bus_arbiter: RTL and testbench
=====================================

// Module: periph_bus_arbiter
// PURPOSE
//   Two-master arbiter for the memory-mapped peripheral bus (timer, LED,
//   switch, 7-seg, UART registers at 0x4000_0000..0x4000_0020).
//   Master 0 is the CPU data port. Master 1 is an auxiliary requester
//   (UART loader / debug). Access is round-robin with an optional bounded lock.
//   Each granted access produces exactly one single-cycle MemRead or
//   MemWrite strobe, so read-to-clear registers (UART_CON irq bits) are
//   never double-read.
// PARAMETERS
//   ADDR_W     32  address width
//   DATA_W     32  data width
//   MAX_BURST  4   max consecutive grants to a locking master while the other waits
// PORTS
//   clk             in   1       system clock
//   reset           in   1       synchronous, active-high reset
//   m0_req/m1_req   in   1       access request; held until ack
//   m0_we/m1_we     in   1       1=write, 0=read; valid with req
//   m0_lock/m1_lock in   1       request to keep the bus for the next access
//   m0_addr/m1_addr in   ADDR_W  byte address
//   m0_wdata/m1_wdata in DATA_W  write data
//   m0_ack/m1_ack   out  1       1-cycle completion pulse
//   m0_rdata/m1_rdata out DATA_W read data; valid from ack, held until the next read ack
//   per_MemRead     out  1       read strobe to peripheral
//   per_MemWrite    out  1       write strobe to peripheral
//   per_Address     out  ADDR_W  peripheral address
//   per_Write_data  out  DATA_W  peripheral write data
//   per_Read_data   in   DATA_W  peripheral combinational read data
//   gnt             out  2       one-hot current owner (00 when IDLE)
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset (sync, reset=1 at posedge): state=IDLE, all outputs 0, rr_ptr=0
//     (m0 first), burst_cnt=0.
//   - Reset mid-access: the access is aborted. No ack is issued. Strobes drop
//     on the next cycle.
//   - FSM IDLE -> ACCESS -> DONE -> IDLE. Each access takes exactly 3 cycles;
//     max throughput is 1 access per 3 cycles.
//   - IDLE: sample req.
//       None: stay in IDLE.
//       One: grant it.
//       Both: grant the rr_ptr master, unless the lock rule applies.
//     Latch addr/wdata/we of the winner into per_* regs. Set gnt. Go to ACCESS.
//   - ACCESS (1 cycle): per_MemWrite=we or per_MemRead=~we, with the latched
//     address and data. On a read, capture per_Read_data at the end of this
//     cycle. Go to DONE.
//   - DONE: strobes=0. Winner's ack=1 for this cycle only. On a read, the
//     winner's rdata is updated; on a write, rdata is unchanged. gnt returns
//     to 00 on exit. Go to IDLE.
//   - Latency: req seen in IDLE at cycle N -> strobe at N+1 -> ack at N+2.
//   - Master handshake: drop req, or present the next request, on the edge
//     where it samples ack=1. A req seen in IDLE is always a new request.
//     Changing addr/we/wdata while req=1 and before ack is illegal; the
//     arbiter uses the values latched in IDLE.
//   - Round robin: after a non-locked access, rr_ptr = the other master.
//   - Lock: if the winner had lock=1 at grant and burst_cnt+1 < MAX_BURST,
//     rr_ptr stays on the winner and burst_cnt increments. Otherwise burst_cnt
//     clears and rr_ptr flips.
//   - Lock with the other master idle: the winner keeps priority; no starvation
//     issue arises.
//   - burst_cnt clears whenever ownership changes.
//   - Lock never blocks the other master for more than MAX_BURST accesses.
//   - Addresses are forwarded unchecked. Decode and default-zero reads are
//     handled by the peripheral.
// TESTING
//   1 m0 read 0x40000010 with switch=0xA5 -> MemRead high exactly 1 cycle at
//     N+1; m0_ack at N+2; m0_rdata=0x000000A5.
//   2 m0 and m1 both request writes every cycle, no lock -> grants alternate
//     m0,m1,m0,m1. Each MemWrite carries the correct master's addr/data.
//     No ack is given to a non-winner.
//   3 m0 lock=1 with continuous reads, m1 continuous req, MAX_BURST=4 -> 4 m0
//     grants, then 1 m1 grant, then m0 again.
//   4 m1 reads 0x40000020 with UART_CON[3:2]=11 -> exactly 1 MemRead cycle;
//     m1_rdata[3:2]=11; a following read returns 00.
//   5 reset asserted during ACCESS -> no ack; next cycle all outputs 0 and
//     gnt=00. After release, m0 wins a tie.
//   6 write access -> m0_rdata keeps its prior read value; ack is 1 cycle;
//     per_Write_data matches m0_wdata latched in IDLE despite later bus changes.

Source files
------------

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the memory-mapped peripheral bus.
// Each grant yields exactly one single-cycle MemRead/MemWrite strobe and one ack pulse.
module periph_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              per_MemRead,
  output logic              per_MemWrite,
  output logic [ADDR_W-1:0] per_Address,
  output logic [DATA_W-1:0] per_Write_data,
  input  logic [DATA_W-1:0] per_Read_data,
  output logic [1:0]        gnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a master raises req with we/addr/wdata/lock stable and holds them
  // until it samples ack=1; on that edge it drops req or presents its next request.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_e;

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  state_e             state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               last_owner_q, last_owner_d;
  logic               we_q, we_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic [DATA_W-1:0]  rdata0_q, rdata0_d;
  logic [DATA_W-1:0]  rdata1_q, rdata1_d;

  logic               win;
  logic               win_lock;
  logic [CNT_W-1:0]   base_cnt;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    win          = 1'b0;
    win_lock     = 1'b0;
    base_cnt     = '0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          win      = (m0_req && m1_req) ? rr_ptr_q : m1_req;
          win_lock = win ? m1_lock : m0_lock;
          // A burst only continues while the same master keeps winning.
          base_cnt = (win == last_owner_q) ? burst_cnt_q : '0;
          if (win_lock && ((int'(base_cnt) + 1) < MAX_BURST)) begin
            burst_cnt_d = base_cnt + CNT_W'(1);
            rr_ptr_d    = win;
          end else begin
            burst_cnt_d = '0;
            rr_ptr_d    = ~win;
          end
          last_owner_d = win;
          we_d         = win ? m1_we    : m0_we;
          addr_d       = win ? m1_addr  : m0_addr;
          wdata_d      = win ? m1_wdata : m0_wdata;
          gnt_d        = win ? 2'b10 : 2'b01;
          mem_read_d   = ~we_d;
          mem_write_d  = we_d;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        ack0_d = gnt_q[0];
        ack1_d = gnt_q[1];
        if (!we_q) begin
          if (gnt_q[0]) rdata0_d = per_Read_data;
          if (gnt_q[1]) rdata1_d = per_Read_data;
        end
        state_d = DONE;
      end
      DONE: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 1'b0;
      burst_cnt_q  <= '0;
      last_owner_q <= 1'b0;
      we_q         <= 1'b0;
      gnt_q        <= 2'b00;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      burst_cnt_q  <= burst_cnt_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      gnt_q        <= gnt_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign m0_ack         = ack0_q;
  assign m1_ack         = ack1_q;
  assign m0_rdata       = rdata0_q;
  assign m1_rdata       = rdata1_q;
  assign per_MemRead    = mem_read_q;
  assign per_MemWrite   = mem_write_q;
  assign per_Address    = addr_q;
  assign per_Write_data = wdata_q;
  assign gnt            = gnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: access-level reference model feeding expected queues,
// a negedge monitor that checks every strobe/ack, directed cases then random traffic.
module tb_periph_bus_arbiter;

  localparam int MAX_BURST = 4;
  localparam logic [31:0] SWITCH = 32'h0000_00A5;

  logic        clk;
  logic        reset;
  logic        m_req[2], m_we[2], m_lock[2], m_ack[2];
  logic [31:0] m_addr[2], m_wdata[2], m_rdata[2];
  logic        per_MemRead, per_MemWrite;
  logic [31:0] per_Address, per_Write_data, per_Read_data;
  logic [1:0]  gnt, dbg_state;

  periph_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m_req[0]), .m0_we(m_we[0]), .m0_lock(m_lock[0]), .m0_addr(m_addr[0]),
    .m0_wdata(m_wdata[0]), .m0_ack(m_ack[0]), .m0_rdata(m_rdata[0]),
    .m1_req(m_req[1]), .m1_we(m_we[1]), .m1_lock(m_lock[1]), .m1_addr(m_addr[1]),
    .m1_wdata(m_wdata[1]), .m1_ack(m_ack[1]), .m1_rdata(m_rdata[1]),
    .per_MemRead(per_MemRead), .per_MemWrite(per_MemWrite), .per_Address(per_Address),
    .per_Write_data(per_Write_data), .per_Read_data(per_Read_data),
    .gnt(gnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- peripheral model ----------------
  bit [31:0] periph_mem [16];
  wire [3:0] pidx = per_Address[5:2];
  assign per_Read_data = (pidx == 4'd4) ? SWITCH : periph_mem[pidx];
  always @(posedge clk) begin
    if (per_MemWrite && pidx != 4'd4) periph_mem[pidx] <= per_Write_data;
    if (per_MemRead && pidx == 4'd8) periph_mem[8][3:2] <= 2'b00;
  end

  // ---------------- reference model ----------------
  typedef struct { bit m; bit we; logic [31:0] addr; logic [31:0] wdata; int cyc; } bus_t;
  typedef struct { int cyc; logic [31:0] rdata; } ack_t;
  bus_t exp_bus_q[$];
  ack_t exp_ack0_q[$];
  ack_t exp_ack1_q[$];
  bit   grant_log[$];

  int        cyc = 0;
  int        busy = 0, rr = 0, bcnt = 0, last_own = 0;
  logic [1:0] exp_gnt = 2'b00;
  bit [31:0] ref_mem [16];
  bit [31:0] hold_model [2];

  always @(posedge clk) begin
    int w, base, widx;
    bus_t b;
    ack_t a;
    cyc++;
    if (reset) begin
      busy = 0; rr = 0; bcnt = 0; last_own = 0; exp_gnt = 2'b00;
      hold_model[0] = 0; hold_model[1] = 0;
      exp_bus_q.delete(); exp_ack0_q.delete(); exp_ack1_q.delete();
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) exp_gnt = 2'b00;
    end else if (m_req[0] || m_req[1]) begin
      w = (m_req[0] && m_req[1]) ? rr : (m_req[1] ? 1 : 0);
      base = (w == last_own) ? bcnt : 0;
      if (m_lock[w] && (base + 1 < MAX_BURST)) begin bcnt = base + 1; rr = w; end
      else begin bcnt = 0; rr = 1 - w; end
      last_own = w;
      widx = int'(m_addr[w][5:2]);
      if (m_we[w]) begin
        if (widx != 4) ref_mem[widx] = m_wdata[w];
        a.rdata = hold_model[w];
      end else begin
        a.rdata = (widx == 4) ? SWITCH : ref_mem[widx];
        if (widx == 8) ref_mem[8][3:2] = 2'b00;
        hold_model[w] = a.rdata;
      end
      b.m = w[0]; b.we = m_we[w]; b.addr = m_addr[w]; b.wdata = m_wdata[w]; b.cyc = cyc;
      a.cyc = cyc + 1;
      exp_bus_q.push_back(b);
      if (w == 0) exp_ack0_q.push_back(a); else exp_ack1_q.push_back(a);
      exp_gnt = (w == 0) ? 2'b01 : 2'b10;
      busy = 2;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] hold_q [2];
  always @(negedge clk) begin
    bus_t b;
    ack_t a;
    if (reset) begin
      hold_q[0] = 0; hold_q[1] = 0;
    end else begin
      check("gnt", gnt, exp_gnt);
      if (per_MemRead || per_MemWrite) begin
        if (exp_bus_q.size() == 0) check("unexpected_strobe", {per_MemWrite, per_MemRead}, 2'b00);
        else begin
          b = exp_bus_q.pop_front();
          grant_log.push_back(gnt[1]);
          check("strobe_cycle", cyc, b.cyc);
          check("strobe_gnt", gnt, b.m ? 2'b10 : 2'b01);
          check("strobe_kind", {per_MemWrite, per_MemRead}, b.we ? 2'b10 : 2'b01);
          check("strobe_addr", per_Address, b.addr);
          if (b.we) check("strobe_wdata", per_Write_data, b.wdata);
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (m_ack[m]) begin
          if ((m == 0 ? exp_ack0_q.size() : exp_ack1_q.size()) == 0)
            check(m == 0 ? "unexpected_ack0" : "unexpected_ack1", m_ack[m], 1'b0);
          else begin
            a = (m == 0) ? exp_ack0_q.pop_front() : exp_ack1_q.pop_front();
            check("ack_cycle", cyc, a.cyc);
            check("ack_rdata", m_rdata[m], a.rdata);
            hold_q[m] = a.rdata;
          end
        end else begin
          check("rdata_hold", m_rdata[m], hold_q[m]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic access(input int m, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit lock, input bit scramble,
                        output logic [31:0] rd);
    int t = 0;
    m_req[m] = 1'b1; m_we[m] = we; m_addr[m] = addr; m_wdata[m] = wdata; m_lock[m] = lock;
    forever begin
      @(negedge clk);
      if (scramble && t == 0) begin
        m_addr[m] = addr ^ 32'h0000_001C;
        m_wdata[m] = ~wdata;
      end
      if (m_ack[m]) break;
      t++;
      if (t > 60) begin
        check("ack_timeout", m_ack[m], 1'b1);
        break;
      end
    end
    rd = m_rdata[m];
    @(posedge clk); #1;
  endtask

  task automatic release_m(input int m);
    m_req[m] = 1'b0; m_lock[m] = 1'b0;
  endtask

  task automatic do_reset();
    for (int m = 0; m < 2; m++) begin m_req[m] = 0; m_lock[m] = 0; m_we[m] = 0; end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_ack0", m_ack[0], 1'b0);
    check("rst_ack1", m_ack[1], 1'b0);
    check("rst_memread", per_MemRead, 1'b0);
    check("rst_memwrite", per_MemWrite, 1'b0);
    check("rst_addr", per_Address, 32'h0);
    check("rst_wdata", per_Write_data, 32'h0);
    check("rst_rdata0", m_rdata[0], 32'h0);
    check("rst_rdata1", m_rdata[1], 32'h0);
    check("rst_gnt", gnt, 2'b00);
    check("rst_state", dbg_state, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic rand_master(input int m, input int n);
    logic [31:0] rd;
    int gap;
    for (int i = 0; i < n; i++) begin
      access(m, 1'($urandom_range(0, 1)), 32'h4000_0000 + 32'($urandom_range(0, 8) * 4),
             $urandom, ($urandom_range(0, 2) == 0), 1'b0, rd);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        release_m(m);
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    release_m(m);
  endtask

  task automatic check_log(input string name, input int n, input logic [15:0] pattern);
    check({name, "_len"}, (grant_log.size() >= n), 1'b1);
    for (int i = 0; i < n && i < grant_log.size(); i++)
      check(name, grant_log[i], pattern[i]);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] rd_a, rd_b;

  initial begin
    reset = 1'b1;
    for (int m = 0; m < 2; m++) begin
      m_req[m] = 0; m_we[m] = 0; m_lock[m] = 0; m_addr[m] = 0; m_wdata[m] = 0;
    end
    do_reset();

    // switch read: single strobe, ack two cycles after the request edge
    access(0, 1'b0, 32'h4000_0010, 32'h0, 1'b0, 1'b0, rd_a);
    release_m(0);
    check("sw_read", rd_a, 32'h0000_00A5);

    // UART_CON read-to-clear
    access(0, 1'b1, 32'h4000_0020, 32'h0000_000C, 1'b0, 1'b0, rd_a);
    release_m(0);
    access(1, 1'b0, 32'h4000_0020, 32'h0, 1'b0, 1'b0, rd_b);
    check("uart_first_bits", rd_b[3:2], 2'b11);
    access(1, 1'b0, 32'h4000_0020, 32'h0, 1'b0, 1'b0, rd_b);
    release_m(1);
    check("uart_second_bits", rd_b[3:2], 2'b00);

    // write leaves rdata alone; bus changes after grant are ignored
    access(0, 1'b0, 32'h4000_0010, 32'h0, 1'b0, 1'b0, rd_a);
    access(0, 1'b1, 32'h4000_0000, 32'h1234_5678, 1'b0, 1'b1, rd_a);
    release_m(0);
    check("write_keeps_rdata", m_rdata[0], 32'h0000_00A5);

    // lock burst: four m0 grants, then m1
    do_reset();
    grant_log.delete();
    fork
      begin for (int i = 0; i < 9; i++) access(0, 1'b0, 32'h4000_0000, 32'h0, 1'b1, 1'b0, rd_a); release_m(0); end
      begin for (int i = 0; i < 3; i++) access(1, 1'b0, 32'h4000_0004, 32'h0, 1'b0, 1'b0, rd_b); release_m(1); end
    join
    check_log("lock_order", 10, 16'b0000_0010_0001_0000);

    // no lock: strict alternation
    do_reset();
    grant_log.delete();
    fork
      begin for (int i = 0; i < 6; i++) access(0, 1'b1, 32'h4000_0008, $urandom, 1'b0, 1'b0, rd_a); release_m(0); end
      begin for (int i = 0; i < 6; i++) access(1, 1'b1, 32'h4000_000C, $urandom, 1'b0, 1'b0, rd_b); release_m(1); end
    join
    check_log("alternate", 12, 16'b0000_1010_1010_1010);

    // reset during ACCESS aborts the read with no ack
    m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h4000_0004; m_lock[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_strobe", per_MemRead, 1'b1);
    do_reset();
    grant_log.delete();
    fork
      begin access(0, 1'b0, 32'h4000_0014, 32'h0, 1'b0, 1'b0, rd_a); release_m(0); end
      begin access(1, 1'b0, 32'h4000_0018, 32'h0, 1'b0, 1'b0, rd_b); release_m(1); end
    join
    check_log("tie_after_reset", 2, 16'b0000_0000_0000_0010);

    // random traffic on both masters
    fork
      rand_master(0, 40);
      rand_master(1, 40);
    join
    repeat (6) @(posedge clk);
    check("left_bus", exp_bus_q.size(), 0);
    check("left_ack0", exp_ack0_q.size(), 0);
    check("left_ack1", exp_ack1_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
